// File: rtl/axis_bram_master_if.sv
// Bus bundle for axis_bram_master: go/busy control, BRAM read port and
// AXI-Stream master channel. Clock and reset stay outside the bundle.
interface axis_bram_master_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int BYTE_COUNT = DATA_WIDTH / 8
);
  logic                  axis_bram_master_go;
  logic                  axis_bram_master_busy;
  logic [ADDR_WIDTH-1:0] axis_mem2m_raddr;
  logic                  axis_mem2m_re;
  logic [DATA_WIDTH-1:0] axis_mem2m_rdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tlast;
  logic [BYTE_COUNT-1:0] m_axis_tkeep;

  modport master (
    input  axis_bram_master_go,
    output axis_bram_master_busy,
    output axis_mem2m_raddr,
    output axis_mem2m_re,
    input  axis_mem2m_rdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tdata,
    output m_axis_tlast,
    output m_axis_tkeep
  );

  modport slave (
    output axis_bram_master_go,
    input  axis_bram_master_busy,
    input  axis_mem2m_raddr,
    input  axis_mem2m_re,
    output axis_mem2m_rdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tlast,
    input  m_axis_tkeep
  );
endinterface

// File: rtl/axis_bram_master.sv
// Streams one FFT_SIZE-word frame out of a 1-cycle-latency BRAM onto AXI-Stream,
// with a 2-entry skid buffer so back-pressure never loses or repeats a word.
module axis_bram_master #(
  parameter int DATA_WIDTH = 64,
  parameter int FFT_SIZE   = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  axis_bram_master_if.master   bus
);

  localparam int ADDR_WIDTH = $clog2(FFT_SIZE);
  localparam int BYTE_COUNT = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FFT_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q;
  logic                  warm_q;
  logic [ADDR_WIDTH-1:0] rd_cnt_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic                  buf_last_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;

  logic                  tvalid;
  logic                  tlast;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  issue_last;
  logic [1:0]            committed;

  assign tvalid = (occ_q != 2'd0);
  assign tlast  = tvalid & buf_last_q[rd_ptr_q];
  assign pop    = tvalid & bus.m_axis_tready;
  assign push   = inflight_q;

  // Words already owned by the buffer once this cycle's pop is taken out;
  // occupancy plus in-flight never exceeds 2, so 2 bits cannot overflow.
  assign committed  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  // warm_q holds off the first read for one cycle, placing the first beat
  // three edges after go is sampled.
  assign issue      = (state_q == READ) && warm_q && (committed < 2'd2);
  assign issue_last = issue && (rd_cnt_q == LAST_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      warm_q          <= 1'b0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};

      case (state_q)
        IDLE: begin
          if (bus.axis_bram_master_go) begin
            state_q  <= READ;
            rd_cnt_q <= '0;
            warm_q   <= 1'b0;
          end
        end
        READ: begin
          warm_q <= 1'b1;
          if (issue) begin
            // Counter parks on the last address so the frame never wraps.
            if (issue_last) state_q  <= DRAIN;
            else            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (pop && tlast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else if (push) begin
      buf_data_q[wr_ptr_q] <= bus.axis_mem2m_rdata;
      buf_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign bus.axis_bram_master_busy = (state_q != IDLE);
  assign bus.axis_mem2m_re         = issue;
  assign bus.axis_mem2m_raddr      = rd_cnt_q;
  assign bus.m_axis_tvalid         = tvalid;
  assign bus.m_axis_tdata          = buf_data_q[rd_ptr_q];
  assign bus.m_axis_tlast          = tlast;
  assign bus.m_axis_tkeep          = {BYTE_COUNT{tvalid}};

endmodule
